// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: pipeline request side and data-memory write side.
// The buffer takes the slave modport; the pipeline/memory environment takes the master modport.
interface store_buffer_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic [31:0] req_pc;
    logic        stall;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_pc;
    logic        dm_ready;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, req_pc,
        output dm_ready,
        input  stall, dm_we, dm_addr, dm_wdata, dm_be, dm_pc
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, req_pc,
        input  dm_ready,
        output stall, dm_we, dm_addr, dm_wdata, dm_be, dm_pc
    );
endinterface

// File: rtl/store_buffer.sv
// In-order posted-write buffer between the M stage and data memory.
// Stores queue here and drain one per cycle; loads to a queued word stall.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    store_buffer_if.slave          sb,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   addr_q  [DEPTH];
    logic [31:0]   wdata_q [DEPTH];
    logic [3:0]    be_q    [DEPTH];
    logic [31:0]   pc_q    [DEPTH];

    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic          enq;
    logic          deq;
    logic          hit;
    logic [AW-1:0] off;

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Store stall uses registered full only, so dm_ready never reaches stall.
    assign enq      = sb.req_valid & sb.req_we & ~full;
    assign deq      = ~empty & sb.dm_ready;
    assign sb.stall = sb.req_valid & (sb.req_we ? full : hit);

    // Word-address match of the request against every live entry.
    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - head_q;
            if ((CW'(off) < count_q) &&
                (addr_q[i][31:2] == sb.req_addr[31:2])) begin
                hit = 1'b1;
            end
        end
    end

    // Head entry drives the memory port; zeros while the buffer is empty.
    always_comb begin
        sb.dm_we    = ~empty;
        sb.dm_addr  = '0;
        sb.dm_wdata = '0;
        sb.dm_be    = '0;
        sb.dm_pc    = '0;
        if (!empty) begin
            sb.dm_addr  = addr_q[head_q];
            sb.dm_wdata = wdata_q[head_q];
            sb.dm_be    = be_q[head_q];
            sb.dm_pc    = pc_q[head_q];
        end
    end

    // Pointer and occupancy bookkeeping; reset discards queued stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                tail_q <= tail_q + 1'b1;
            end
            if (deq) begin
                head_q <= head_q + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload is written at the tail; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            addr_q[tail_q]  <= sb.req_addr;
            wdata_q[tail_q] <= sb.req_wdata;
            be_q[tail_q]    <= sb.req_be;
            pc_q[tail_q]    <= sb.req_pc;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: queue model checked every cycle,
// plus hand-computed checks of the DM write log.
module tb_store_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] pc;
    } ent_t;

    logic       clk;
    logic       reset;
    logic [2:0] count;
    logic       empty;
    logic       full;

    store_buffer_if sb ();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb.slave),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];
    ent_t log_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack(input ent_t e);
        return {28'd0, e.a, e.d, e.be, e.pc};
    endfunction

    // One clock: check outputs mid-cycle, then advance the model on the edge.
    task automatic tick();
        bit   mfull;
        bit   hit;
        bit   drain;
        bit   acc;
        logic exp_stall;
        ent_t e;
        ent_t got;
        @(negedge clk);
        mfull = (mq.size() == DEPTH);
        hit = 0;
        foreach (mq[i]) begin
            if (mq[i].a[31:2] == sb.req_addr[31:2]) hit = 1;
        end
        exp_stall = sb.req_valid && (sb.req_we ? mfull : hit);
        got = '{sb.dm_addr, sb.dm_wdata, sb.dm_be, sb.dm_pc};
        if (!reset) begin
            check("stall", {127'd0, sb.stall}, {127'd0, exp_stall});
            check("count", {125'd0, count}, 128'(mq.size()));
            check("dm_we", {127'd0, sb.dm_we}, {127'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                check("dm_head", pack(got), pack(mq[0]));
            end else begin
                check("dm_idle", pack(got), 128'd0);
            end
        end
        drain = (mq.size() != 0) && sb.dm_ready;
        acc   = sb.req_valid && sb.req_we && !mfull;
        if (drain && !reset) log_q.push_back(got);
        e = '{sb.req_addr, sb.req_wdata, sb.req_be, sb.req_pc};
        @(posedge clk);
        if (reset) begin
            mq.delete();
        end else begin
            if (drain) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         input logic [31:0] pc);
        sb.req_valid = v;
        sb.req_we    = we;
        sb.req_addr  = a;
        sb.req_wdata = d;
        sb.req_be    = be;
        sb.req_pc    = pc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        int cyc;
        reset = 1'b1;
        sb.dm_ready = 1'b0;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // Reset then idle.
        check("rst_count", {125'd0, count}, 128'd0);
        check("rst_empty", {127'd0, empty}, 128'd1);
        check("rst_full", {127'd0, full}, 128'd0);
        check("rst_dm_we", {127'd0, sb.dm_we}, 128'd0);
        for (int i = 0; i < 5; i++) tick();

        // Single store with dm_ready=1.
        sb.dm_ready = 1'b1;
        drive(1'b1, 1'b1, 32'h10, 32'h1234_5678, 4'hF, 32'h3000);
        tick();
        idle();
        check("s1_dm_we", {127'd0, sb.dm_we}, 128'd1);
        check("s1_addr", {96'd0, sb.dm_addr}, 128'h10);
        check("s1_wdata", {96'd0, sb.dm_wdata}, 128'h1234_5678);
        check("s1_be", {124'd0, sb.dm_be}, 128'hF);
        check("s1_pc", {96'd0, sb.dm_pc}, 128'h3000);
        tick();
        check("s1_empty", {127'd0, empty}, 128'd1);

        // Fill to full with memory busy, then drain in order.
        log_q.delete();
        sb.dm_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'(4 * i), 32'hD000 + 32'(i), 4'hF,
                  32'h3100 + 32'(4 * i));
            tick();
        end
        drive(1'b1, 1'b1, 32'h10, 32'hD004, 4'hF, 32'h3110);
        #1;
        check("fill_stall", {127'd0, sb.stall}, 128'd1);
        check("fill_full", {127'd0, full}, 128'd1);
        tick();
        sb.dm_ready = 1'b1;
        #1;
        check("fill_stall_drain", {127'd0, sb.stall}, 128'd1);
        tick();
        #1;
        check("fill_accept", {127'd0, sb.stall}, 128'd0);
        tick();
        idle();
        for (int i = 0; i < 6; i++) tick();
        check("fill_nwr", 128'(log_q.size()), 128'd5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            check("fill_order", {96'd0, log_q[i].a}, 128'(4 * i));
        end

        // Load hazard against a byte store in the same word.
        sb.dm_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h21, 32'h0000_AB00, 4'b0010, 32'h5000);
        tick();
        drive(1'b1, 1'b0, 32'h20, 32'd0, 4'd0, 32'h5004);
        #1;
        check("ld_hz", {127'd0, sb.stall}, 128'd1);
        tick();
        check("ld_hz_hold", {127'd0, sb.stall}, 128'd1);
        drive(1'b1, 1'b0, 32'h24, 32'd0, 4'd0, 32'h5008);
        #1;
        check("ld_nohz", {127'd0, sb.stall}, 128'd0);
        tick();
        drive(1'b1, 1'b0, 32'h20, 32'd0, 4'd0, 32'h5004);
        sb.dm_ready = 1'b1;
        #1;
        check("ld_hz_drain", {127'd0, sb.stall}, 128'd1);
        tick();
        check("ld_release", {127'd0, sb.stall}, 128'd0);
        tick();
        idle();
        tick();

        // Wrap-around with dm_ready toggling every cycle.
        log_q.delete();
        idx = 0;
        cyc = 0;
        while (idx < 10 && cyc < 200) begin
            bit will_acc;
            drive(1'b1, 1'b1, 32'h100 + 32'(4 * idx), 32'hA000_0000 + 32'(idx),
                  4'hF, 32'h4000 + 32'(4 * idx));
            sb.dm_ready = cyc[0];
            will_acc = (mq.size() != DEPTH);
            tick();
            if (will_acc) idx++;
            cyc++;
        end
        check("wrap_bound", 128'(idx), 128'd10);
        idle();
        sb.dm_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("wrap_nwr", 128'(log_q.size()), 128'd10);
        for (int i = 0; i < 10 && i < log_q.size(); i++) begin
            check("wrap_pc", {96'd0, log_q[i].pc}, 128'(32'h4000 + 4 * i));
            check("wrap_data", {96'd0, log_q[i].d},
                  128'(32'hA000_0000 + i));
        end

        // Reset with stores queued: they must never reach memory.
        log_q.delete();
        sb.dm_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'hBEEF, 4'hF,
                  32'h6000 + 32'(4 * i));
            tick();
        end
        check("pre_rst_count", {125'd0, count}, 128'd3);
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_count", {125'd0, count}, 128'd0);
        check("mid_rst_dm_we", {127'd0, sb.dm_we}, 128'd0);
        check("mid_rst_empty", {127'd0, empty}, 128'd1);
        sb.dm_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("mid_rst_nwr", 128'(log_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the M-stage pipeline register and the data memory. Accepts stores from the pipeline at one per cycle, queues up to DEPTH of them in order, and drains them to data memory one per cycle while data memory is ready. Loads never bypass a queued store to the same word: a load whose word address matches any queued entry stalls the pipeline until that entry has drained. Every store's address, data, byte-enable and PC are carried unchanged to the memory side, so commit logging stays exact.

## Interface
- DEPTH, 4, number of entries; power of two, 2..16.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- req_valid  input  1  M stage presents a memory access this cycle.
- req_we  input  1  1 = store, 0 = load; ignored when req_valid=0.
- req_addr  input  32  byte address of the access.
- req_wdata  input  32  store data, already lane-aligned to the byte-enables.
- req_be  input  4  store byte-enables; bit k = byte lane k (bits [8k+7:8k]).
- req_pc  input  32  PC of the instruction, carried with the entry.
- stall  output  1  combinational; 1 = the current request is not accepted and the pipeline must hold.
- dm_we  output  1  head entry valid; write request to data memory.
- dm_addr  output  32  head entry address.
- dm_wdata  output  32  head entry data.
- dm_be  output  4  head entry byte-enables.
- dm_pc  output  32  head entry PC.
- dm_ready  input  1  data memory accepts the head entry on this edge when dm_we=1.
- count  output  log2(DEPTH)+1  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

## Operation
- Storage: circular array of DEPTH entries, each holding {addr, wdata, be, pc}. Head pointer, tail pointer and count are registers.
- Enqueue: a store is accepted when req_valid=1, req_we=1 and full=0. It is written at the tail, the tail advances, and count increments.
- Drain: when dm_we=1 and dm_ready=1, the head entry is retired, the head advances, and count decrements.
- Pointers wrap from DEPTH-1 to 0.
- dm_* outputs show the head entry whenever empty=0. dm_we = ~empty.
- When empty=1, dm_addr, dm_wdata, dm_be and dm_pc are 0.
- Store stall: stall=1 when a store is requested and full=1. This holds even if a drain happens in the same cycle, so the stall depends only on registered state.
- Load hazard: stall=1 when a load is requested and any valid entry has addr[31:2] == req_addr[31:2]. Byte-enables are not considered. A load that does not match passes with stall=0, and data memory is read directly.
- Load when not hazarded: the buffer does nothing.
- Idle: when req_valid=0, stall=0.
- Simultaneous enqueue and drain with full=0: the entry is written at the tail and the head retires on the same edge, so count is unchanged.
- Ordering: entries drain strictly in acceptance order. There is no merging or coalescing, and every store produces exactly one DM write.
- Reset: head=0, tail=0, count=0, empty=1, full=0, dm_we=0, dm_* data outputs 0. Reset while entries are queued discards them without writing to DM. reset has priority over enqueue and drain on the same edge.

## Timing
- Store accepted on edge N appears on dm_we/dm_* during cycle N+1 at the earliest, if the buffer was empty. Minimum store-to-DM latency is 1 cycle.
- Throughput is 1 enqueue and 1 drain per cycle.
- stall is combinational from the req_* inputs plus registered state. There is no path from dm_ready to stall.
- A hazarded load is released in the cycle after the last matching entry drains. With one matching entry at the head and dm_ready=1, stall is 1 for exactly one cycle.
- count, empty and full update on the edge after the event.

## Test plan
- Reset then idle: after reset, count=0, empty=1, dm_we=0, stall=0 for 5 cycles with req_valid=0.
- Single store, dm_ready=1:
  - stimulus: store addr 0x0000_0010, data 0x1234_5678, be 4'hF, pc 0x3000 on cycle 1.
  - required response: dm_we=1 with those exact values in cycle 2, empty=1 in cycle 3.
- Fill and stall, dm_ready=0:
  - stimulus: 5 back-to-back stores to 0x0, 0x4, 0x8, 0xC, 0x10.
  - required response: the first 4 are accepted, the 5th sees stall=1 and full=1.
  - then raise dm_ready: the 5th is accepted on the cycle after the first drain, and DM writes occur in order 0x0, 0x4, 0x8, 0xC, 0x10.
- Load hazard, dm_ready=0:
  - stimulus: store byte to 0x0000_0021 (be 4'b0010), then load word 0x0000_0020.
  - required response: stall=1 while dm_ready=0.
  - then raise dm_ready: stall=0 the cycle after the drain.
  - a load of 0x0000_0024 in the same state has stall=0.
- Wrap-around with DEPTH=4: 10 stores with dm_ready toggling 1/0 every cycle. Required response: DM sees all 10 in order with matching pc values and no drops or duplicates.
- Reset mid-operation: queue 3 stores with dm_ready=0, then assert reset for 1 cycle. Required response: count=0, dm_we=0, and none of the 3 stores ever reach DM.
